// File: rtl/calc_pipe_q.sv
// calc_pipe_q: pipelined three-operand polynomial calculator.
// Each operand channel (A/B/C) has its own push/stop input FIFO. When all
// three FIFOs hold data and the output queue has credit, one word is popped
// from each FIFO and the operation is issued. The result reaches the output
// queue STAGES cycles later.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   A, B, C            operand data, qualified by pushA/pushB/pushC
//   stopA/B/C          channel FIFO full (registered)
//   mode               0/3: full polynomial, 1: a*b+c, 2: a+b+c (sampled at issue)
//   Z, pushZ, stopZ    output queue head, transfer strobe, consumer hold
//   err                sticky {C,B,A} overflow flags (push while stop)
module calc_pipe_q #(
    parameter int unsigned W        = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STAGES   = 4,
    parameter int unsigned OQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] C,
    input  logic         pushA,
    input  logic         pushB,
    input  logic         pushC,
    output logic         stopA,
    output logic         stopB,
    output logic         stopC,
    input  logic [1:0]   mode,
    output logic [W-1:0] Z,
    output logic         pushZ,
    input  logic         stopZ,
    output logic [2:0]   err
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned QPW  = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
    localparam int unsigned QCW  = $clog2(OQ_DEPTH) + 1;
    localparam int unsigned NRES = STAGES - 2;
    localparam int unsigned VW   = $clog2(STAGES + 1);
    localparam int unsigned FW   = $clog2(OQ_DEPTH + STAGES + 1);

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    logic [W-1:0] chData [3];
    logic [W-1:0] chHead [3];
    logic [2:0]   chPush;
    logic [2:0]   chStop;
    logic [2:0]   chNonEmpty;
    logic         issue;

    assign chData[0] = A;
    assign chData[1] = B;
    assign chData[2] = C;
    assign chPush    = {pushC, pushB, pushA};
    assign stopA     = chStop[0];
    assign stopB     = chStop[1];
    assign stopC     = chStop[2];

    for (genvar ch = 0; ch < 3; ch++) begin : gChan
        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] wrPtr;
        logic [PW-1:0] rdPtr;
        logic [CW-1:0] count;
        logic [CW-1:0] countNext;
        logic          stopR;
        logic          errR;
        logic          wrEn;

        // A push while full is dropped; stop mirrors count==DEPTH after the edge
        assign wrEn = chPush[ch] & ~stopR;

        always_comb begin
            countNext = count;
            if (wrEn && !issue) begin
                countNext = count + CW'(1);
            end else if (!wrEn && issue) begin
                countNext = count - CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wrPtr <= '0;
                rdPtr <= '0;
                count <= '0;
                stopR <= 1'b0;
                errR  <= 1'b0;
            end else begin
                if (wrEn) begin
                    wrPtr <= wrPtr + PW'(1);
                end
                if (issue) begin
                    rdPtr <= rdPtr + PW'(1);
                end
                count <= countNext;
                stopR <= (countNext == CW'(DEPTH));
                if (chPush[ch] && stopR) begin
                    errR <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (wrEn) begin
                mem[wrPtr] <= chData[ch];
            end
        end

        assign chHead[ch]     = mem[rdPtr];
        assign chNonEmpty[ch] = (count != '0);
        assign chStop[ch]     = stopR;
        assign err[ch]        = errR;
    end

    // ------------------------------------------------------------------
    // Issue control: credit covers everything in the pipe plus the queue
    // ------------------------------------------------------------------
    logic [NRES-1:0] resV;
    logic            s1V;
    logic            s2V;
    logic [VW-1:0]   validCnt;
    logic [QCW-1:0]  qCount;
    logic [FW-1:0]   inFlight;

    assign validCnt = VW'($countones({resV, s2V, s1V}));
    assign inFlight = FW'(qCount) + FW'(validCnt);
    assign issue    = (&chNonEmpty) && (inFlight < FW'(OQ_DEPTH));

    // ------------------------------------------------------------------
    // Arithmetic pipeline
    // Stage 1: squares and pairwise products
    // Stage 2: a^4, b^3, a^2*bc and partial sums
    // Stage 3: final combine and mode select, then plain delay stages
    // ------------------------------------------------------------------
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [W-1:0] opC;

    assign opA = chHead[0];
    assign opB = chHead[1];
    assign opC = chHead[2];

    logic [1:0]   s1Mode;
    logic [W-1:0] s1A, s1B, s1C;
    logic [W-1:0] s1A2, s1B2, s1C2;
    logic [W-1:0] s1AB, s1AC, s1BC;
    logic [W-1:0] s1Sum;

    logic [1:0]   s2Mode;
    logic [W-1:0] s2A, s2A4, s2B3, s2A2BC;
    logic [W-1:0] s2Mix, s2Lin, s2Sum;

    logic [W-1:0] resR [NRES];

    // Valid bits carry the only control state, so only they are reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1V  <= 1'b0;
            s2V  <= 1'b0;
            resV <= '0;
        end else begin
            s1V     <= issue;
            s2V     <= s1V;
            resV[0] <= s2V;
            for (int unsigned k = 1; k < NRES; k++) begin
                resV[k] <= resV[k-1];
            end
        end
    end

    // Datapath registers load only when their stage carries an operation
    always_ff @(posedge clk) begin
        if (issue) begin
            s1Mode <= mode;
            s1A    <= opA;
            s1B    <= opB;
            s1C    <= opC;
            s1A2   <= opA * opA;
            s1B2   <= opB * opB;
            s1C2   <= opC * opC;
            s1AB   <= opA * opB;
            s1AC   <= opA * opC;
            s1BC   <= opB * opC;
            s1Sum  <= opA + opB + opC;
        end
        if (s1V) begin
            s2Mode <= s1Mode;
            s2A    <= s1A;
            s2A4   <= s1A2 * s1A2;
            s2B3   <= s1B2 * s1B;
            s2A2BC <= s1A2 * s1BC;
            s2Mix  <= s1C2 + s1AB + s1AC + s1BC;
            s2Lin  <= s1AB + s1C;
            s2Sum  <= s1Sum;
        end
        if (s2V) begin
            case (s2Mode)
                2'd1:    resR[0] <= s2Lin;
                2'd2:    resR[0] <= s2Sum;
                default: resR[0] <= s2A4 * s2A + s2B3 + s2Mix + s2A2BC;
            endcase
        end
        for (int unsigned k = 1; k < NRES; k++) begin
            if (resV[k-1]) begin
                resR[k] <= resR[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output queue; credit guarantees a free slot whenever a result exits
    // ------------------------------------------------------------------
    logic [W-1:0]   qMem [OQ_DEPTH];
    logic [QPW-1:0] qWr;
    logic [QPW-1:0] qRd;
    logic           exitV;
    logic [W-1:0]   exitR;
    logic           qNonEmpty;

    assign exitV     = resV[NRES-1];
    assign exitR     = resR[NRES-1];
    assign qNonEmpty = (qCount != '0);

    // pushZ follows stopZ combinationally so the consumer can hold in-cycle
    assign pushZ = qNonEmpty & ~stopZ;
    assign Z     = qNonEmpty ? qMem[qRd] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qWr    <= '0;
            qRd    <= '0;
            qCount <= '0;
        end else begin
            if (exitV) begin
                qWr <= qWr + QPW'(1);
            end
            if (pushZ) begin
                qRd <= qRd + QPW'(1);
            end
            qCount <= qCount + QCW'(exitV) - QCW'(pushZ);
        end
    end

    always_ff @(posedge clk) begin
        if (exitV) begin
            qMem[qWr] <= exitR;
        end
    end

endmodule

// File: tb/tb_calc_pipe_q.sv
// Directed bench for calc_pipe_q with a short random-traffic tail.
module tb_calc_pipe_q;

    localparam int unsigned W      = 32;
    localparam int unsigned STAGES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A, B, C;
    logic         pushA, pushB, pushC;
    logic         stopA, stopB, stopC;
    logic [1:0]   mode;
    logic [W-1:0] Z;
    logic         pushZ;
    logic         stopZ;
    logic [2:0]   err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    calc_pipe_q #(.W(W), .DEPTH(4), .STAGES(STAGES), .OQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C),
        .pushA(pushA), .pushB(pushB), .pushC(pushC),
        .stopA(stopA), .stopB(stopB), .stopC(stopC),
        .mode(mode), .Z(Z), .pushZ(pushZ), .stopZ(stopZ), .err(err)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [1:0] m);
        case (m)
            2'd1:    return a * b + c;
            2'd2:    return a + b + c;
            default: return a * a * a * a * a + b * b * b + c * c + a * b + a * c + b * c
                            + a * a * b * c;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushT(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        A = a; B = b; C = c;
        pushA = 1'b1; pushB = 1'b1; pushC = 1'b1;
        tick();
        pushA = 1'b0; pushB = 1'b0; pushC = 1'b0;
    endtask

    // Wait (bounded) for the next transfer and check its value
    task automatic waitResult(input string tag, input logic [W-1:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (pushZ === 1'b1) begin
                seen = 1'b1;
                check(tag, Z, exp);
            end
            tick();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int stale;
        int got;
        bit seen;
        logic [W-1:0] expQ [$];

        rst = 1'b0; stopZ = 1'b0; mode = 2'd0;
        A = '0; B = '0; C = '0;
        pushA = 1'b0; pushB = 1'b0; pushC = 1'b0;
        tick(); tick();
        check("rst_stop",  32'({stopC, stopB, stopA}), 32'd0);
        check("rst_pushZ", 32'(pushZ), 32'd0);
        check("rst_Z",     Z, 32'd0);
        check("rst_err",   32'(err), 32'd0);
        rst = 1'b1;
        tick();

        // T1: single triple, latency from push edge to first pushZ cycle
        mode = 2'd0;
        pushT(2, 3, 4);
        lat = 0;
        while (pushZ !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'(STAGES + 1));
        check("t1_z", Z, 32'd149);
        tick();
        check("t1_single", 32'(pushZ), 32'd0);

        // T2: skewed arrivals, then modes 1 and 2
        A = 32'hFFFF_FFFF; pushA = 1'b1; tick(); pushA = 1'b0;
        C = 32'd3;         pushC = 1'b1; tick(); pushC = 1'b0;
        tick();
        B = 32'hFFFF_FFFE; pushB = 1'b1; tick(); pushB = 1'b0;
        waitResult("t2_mode0", 32'hFFFF_FFF3);
        mode = 2'd1;
        pushT(2, 3, 4);
        waitResult("t2_mode1", 32'd10);
        mode = 2'd2;
        pushT(2, 3, 4);
        waitResult("t2_mode2", 32'd9);

        // T3: consumer holds; queue fills, issue stalls, FIFOs fill to DEPTH
        stopZ = 1'b1;
        for (int i = 1; i <= 8; i++) pushT(32'(i), 32'(10 * i), 32'(100 * i));
        repeat (10) tick();
        check("t3_stops", 32'({stopC, stopB, stopA}), 32'd7);
        check("t3_hold",  32'(pushZ), 32'd0);
        check("t3_head",  Z, 32'd111);
        check("t3_err",   32'(err), 32'd0);

        // T4: push on full channel A is dropped and flagged
        A = 32'd999; pushA = 1'b1; tick(); pushA = 1'b0;
        check("t4_err", 32'(err), 32'd1);
        check("t4_stopA", 32'(stopA), 32'd1);
        stopZ = 1'b0;
        #1;
        for (int i = 1; i <= 8; i++) waitResult("t3_order", 32'(111 * i));
        pushT(100, 20, 3);
        waitResult("t4_pair", 32'd123);
        check("t4_sticky", 32'(err), 32'd1);

        // T5: reset with operations in flight and a result at the queue head
        mode = 2'd0;
        pushT(1, 1, 1); pushT(1, 1, 1); pushT(1, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (pushZ === 1'b1) seen = 1'b1;
            else tick();
        end
        check("t5_first", 32'(seen), 32'd1);
        check("t5_first_z", Z, 32'd7);
        rst = 1'b0;
        #1;
        check("t5_pushZ", 32'(pushZ), 32'd0);
        check("t5_Z", Z, 32'd0);
        tick();
        rst = 1'b1;
        stale = 0;
        for (int i = 0; i < 15; i++) begin
            if (pushZ !== 1'b0) stale++;
            tick();
        end
        check("t5_stale", 32'(stale), 32'd0);
        check("t5_err", 32'(err), 32'd0);
        pushT(2, 3, 4);
        waitResult("t5_after", 32'd149);

        // T6: random operands, push gaps and consumer stalls, one mode per segment
        for (int seg = 0; seg < 4; seg++) begin
            mode = 2'(seg);
            got = 0;
            fork
                begin
                    for (int k = 0; k < 12; k++) begin
                        logic [W-1:0] ra, rb, rc;
                        repeat ($urandom_range(0, 3)) tick();
                        for (int w = 0; w < 500 && (stopA | stopB | stopC); w++) tick();
                        ra = $urandom(); rb = $urandom(); rc = $urandom();
                        expQ.push_back(model(ra, rb, rc, 2'(seg)));
                        pushT(ra, rb, rc);
                    end
                end
                begin
                    for (int cyc = 0; cyc < 2000 && got < 12; cyc++) begin
                        stopZ = ($urandom_range(0, 9) < 3);
                        #1;
                        if (pushZ === 1'b1) begin
                            check("t6_avail", 32'(expQ.size() > 0), 32'd1);
                            if (expQ.size() > 0) check("t6_z", Z, expQ.pop_front());
                            got++;
                        end
                        @(posedge clk);
                        #1;
                    end
                end
            join
            stopZ = 1'b0;
            check("t6_count", 32'(got), 32'd12);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
